// File: rtl/riscv_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : riscv_run_ctrl
//  Description : Test-harness run controller for a RISC-V core. Holds the
//                core, streams a program into instruction memory, releases
//                the core until it retires the halt instruction or a cycle
//                budget expires, re-holds the core and dumps the 32
//                architectural registers through register-file read port 1.
//  Options     : define RISCV_RUN_CTRL_RETIRE_CNT_EN to add o_retire_count,
//                a saturating count of register-writing retirements in RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_ctrl #(
    parameter int          IMEM_DEPTH     = 1024,
    parameter int          ADDR_W         = 10,
    parameter int          TIMEOUT_CYCLES = 10000,
    parameter logic [31:0] HALT_INSTR     = 32'h0000_0073,
    parameter int          CNT_W          = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    // program stream
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic [31:0]       i_load_data,
    input  logic              i_load_last,
    // instruction memory write port
    output logic              o_imem_write,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    // core control and monitor tap
    output logic              o_core_hold,
    input  logic [31:0]       i_monitor_instr,
    input  logic              i_monitor_regwrite,
    // register-file read port 1
    output logic [4:0]        o_rf_raddr1,
    input  logic [31:0]       i_rf_rdata1,
    // register dump stream
    output logic              o_dump_valid,
    output logic [4:0]        o_dump_idx,
    output logic [31:0]       o_dump_data,
    // run status
    output logic              o_done,
    output logic              o_timeout,
    output logic              o_load_err
`ifdef RISCV_RUN_CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_retire_count
`endif
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_DUMP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR    = ADDR_W'(IMEM_DEPTH - 1);
    localparam logic [CNT_W-1:0]  C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]        C_LAST_REG     = 5'd31;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;        // next imem word address to write
    logic              r_imem_write;
    logic [ADDR_W-1:0] r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_load_err;
    logic [CNT_W-1:0]  r_cycle_cnt;   // cycles spent in RUN, 0 on the first
    logic              r_timeout;
    logic [4:0]        r_rd_addr;     // register index presented to the RF
    logic              r_rd_issue;    // r_rd_addr is a live read request
    logic              r_dump_valid;
    logic [4:0]        r_dump_idx;

    // ------------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------------
    logic       w_start_ok;
    logic       w_load_hs;
    logic       w_addr_full;
    logic       w_load_end;
    logic       w_halt;
    logic       w_cyc_expired;
    logic       w_run_end;
    logic       w_dump_end;
    logic [2:0] w_state_nxt;

    // start is only meaningful when no run is in progress
    assign w_start_ok    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    // no skid buffer: a word is taken only while the FSM sits in LOAD
    assign w_load_hs     = i_load_valid && (r_state == S_LOAD);
    assign w_addr_full   = (r_addr == C_LAST_ADDR);
    // the top memory word closes the load even without load_last, so the
    // address never wraps onto already-written words
    assign w_load_end    = w_load_hs && (i_load_last || w_addr_full);
    assign w_halt        = (r_state == S_RUN) && (i_monitor_instr == HALT_INSTR);
    assign w_cyc_expired = (r_state == S_RUN) && (r_cycle_cnt == C_TIMEOUT_LAST);
    assign w_run_end     = w_halt || w_cyc_expired;
    assign w_dump_end    = (r_state == S_DUMP) && r_dump_valid && (r_dump_idx == C_LAST_REG);

    // Next-state decode for the run sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)  w_state_nxt = S_LOAD;
            S_LOAD:  if (w_load_end)  w_state_nxt = S_RUN;
            S_RUN:   if (w_run_end)   w_state_nxt = S_DUMP;
            S_DUMP:  if (w_dump_end)  w_state_nxt = S_DONE;
            S_DONE:  if (w_start_ok)  w_state_nxt = S_LOAD;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program load: register each accepted word into a one-cycle imem write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr       <= '0;
            r_imem_write <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_wdata <= '0;
            r_load_err   <= 1'b0;
        end else begin
            r_imem_write <= w_load_hs;
            if (w_start_ok) begin
                r_addr     <= '0;
                r_load_err <= 1'b0;
            end else if (w_load_hs) begin
                r_imem_addr  <= r_addr;
                r_imem_wdata <= i_load_data;
                r_addr       <= r_addr + ADDR_W'(1);
                if (w_addr_full && !i_load_last) begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

    // Run phase: cycle budget and timeout flag (halt takes priority)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cycle_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_load_end) begin
                r_cycle_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            end

            if (w_start_ok) begin
                r_timeout <= 1'b0;
            end else if (w_cyc_expired && !w_halt) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Register dump: issue reads 0..31, and pair each with the RF data that
    // returns one cycle later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_addr    <= '0;
            r_rd_issue   <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_idx   <= '0;
        end else if ((r_state == S_RUN) && w_run_end) begin
            r_rd_addr    <= '0;
            r_rd_issue   <= 1'b1;
            r_dump_valid <= 1'b0;
        end else if (r_state == S_DUMP) begin
            r_dump_valid <= r_rd_issue;
            r_dump_idx   <= r_rd_addr;
            if (r_rd_issue) begin
                if (r_rd_addr == C_LAST_REG) begin
                    r_rd_issue <= 1'b0;
                end else begin
                    r_rd_addr <= r_rd_addr + 5'd1;
                end
            end
        end else begin
            r_rd_issue   <= 1'b0;
            r_dump_valid <= 1'b0;
        end
    end

`ifdef RISCV_RUN_CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    // Saturating count of register-writing retirements during RUN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_start_ok) begin
            r_retire_cnt <= '0;
        end else if ((r_state == S_RUN) && i_monitor_regwrite && !(&r_retire_cnt)) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign o_retire_count = r_retire_cnt;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_load_ready = (r_state == S_LOAD);
    assign o_core_hold  = (r_state != S_RUN);
    assign o_imem_write = r_imem_write;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_wdata = r_imem_wdata;
    assign o_rf_raddr1  = r_rd_addr;
    assign o_dump_valid = r_dump_valid;
    assign o_dump_idx   = r_dump_idx;
    // RF read data arrives in the beat after its address, which is exactly
    // the cycle the matching dump beat is flagged valid
    assign o_dump_data  = r_dump_valid ? i_rf_rdata1 : 32'd0;
    assign o_done       = (r_state == S_DONE);
    assign o_timeout    = r_timeout;
    assign o_load_err   = r_load_err;

endmodule
`default_nettype wire
